// File: rtl/vector_add_sequencer.sv
// Tile sequencer for the fp16 bias vector adder. It gathers x/bias pairs into a
// NUM_UNITS-wide tile, pulses the adder, waits for the results and streams them out.
module vector_add_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_UNITS   = 64,
    parameter int LEN_WIDTH   = 16,
    parameter int WAIT_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  add_start,
    output logic [NUM_UNITS-1:0]  add_active_units,
    output logic [DATA_WIDTH-1:0] add_x    [NUM_UNITS],
    output logic [DATA_WIDTH-1:0] add_bias [NUM_UNITS],
    input  logic [DATA_WIDTH-1:0] add_out  [NUM_UNITS],
    input  logic                  add_ready
);
    localparam int IDX_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int LANE_W = $clog2(NUM_UNITS + 1);
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_UNITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DRAIN} state_t;

    state_t                state, next_state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LANE_W-1:0]     lane;
    logic [LANE_W-1:0]     tile_count;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] result [NUM_UNITS];

    logic             in_fire, out_fire, fill_done, capture, tile_last, tile_done;
    logic [IDX_W-1:0] idx;

    assign idx       = lane[IDX_W-1:0];
    assign in_fire   = (state == FILL) && in_valid;
    assign out_fire  = (state == DRAIN) && out_ready;
    assign fill_done = in_fire && ((lane == LAST_LANE) || (remaining == LEN_WIDTH'(1)));
    assign capture   = (state == WAIT) && (wait_cnt >= CNT_LIMIT) && add_ready;
    assign tile_last = (lane == tile_count - LANE_W'(1));
    assign tile_done = out_fire && tile_last;

    assign busy     = (state != IDLE);
    assign out_data = result[idx];
    assign out_last = (state == DRAIN) && (remaining == '0) && tile_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_start  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) next_state = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (fill_done) next_state = ISSUE;
            end
            ISSUE: begin
                add_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (capture) next_state = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (tile_done) next_state = (remaining != '0) ? FILL : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The tile operands stay untouched from ISSUE until the results are captured,
    // so the adder can sample them at any point during its latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining        <= '0;
            lane             <= '0;
            tile_count       <= '0;
            wait_cnt         <= '0;
            add_active_units <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                add_x[i]    <= '0;
                add_bias[i] <= '0;
                result[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining        <= cmd_len;
                        lane             <= '0;
                        add_active_units <= '0;
                    end
                end
                FILL: begin
                    if (in_fire) begin
                        add_x[idx]            <= in_x;
                        add_bias[idx]         <= in_bias;
                        add_active_units[idx] <= 1'b1;
                        lane                  <= lane + LANE_W'(1);
                        remaining             <= remaining - LEN_WIDTH'(1);
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (wait_cnt < CNT_LIMIT) wait_cnt <= wait_cnt + CNT_W'(1);
                    if (capture) begin
                        for (int i = 0; i < NUM_UNITS; i++) result[i] <= add_out[i];
                        tile_count <= lane;
                        lane       <= '0;
                    end
                end
                DRAIN: begin
                    if (tile_done) begin
                        lane <= '0;
                        if (remaining != '0) add_active_units <= '0;
                    end else if (out_fire) begin
                        lane <= lane + LANE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_add_sequencer.sv
// Scoreboard bench for vector_add_sequencer with a behavioural fp16 adder model
// that handles the small integer operands used by the directed vectors.
module tb_vector_add_sequencer;
    localparam int DW = 16;
    localparam int NU = 64;
    localparam int LW = 16;
    localparam int WC = 6;

    logic          clk, reset;
    logic          cmd_valid, cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_x, in_bias;
    logic          out_valid, out_ready, out_last, busy, add_start, add_ready;
    logic [DW-1:0] out_data;
    logic [NU-1:0] add_active_units;
    logic [DW-1:0] add_x [NU];
    logic [DW-1:0] add_bias [NU];
    logic [DW-1:0] add_out [NU];

    vector_add_sequencer #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .LEN_WIDTH(LW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .add_start(add_start), .add_active_units(add_active_units),
        .add_x(add_x), .add_bias(add_bias), .add_out(add_out), .add_ready(add_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_count = 0;
    int in_ready_cycles = 0;
    int out_valid_cycles = 0;
    int last_start_cyc = 0;
    logic toggle_ready = 1'b0;
    logic hold_ready = 1'b0;

    logic [16:0]   exp_q[$];
    logic [NU-1:0] exp_mask_q[$];
    logic [15:0]   stim_x[$];
    logic [15:0]   stim_b[$];
    logic [15:0]   stim_exp[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkTrue(input string name, input logic ok, input int actual, input int required);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    function automatic int fp16ToInt(input logic [15:0] h);
        int e;
        if (h[14:10] == 5'd0) return 0;
        e = int'(h[14:10]) - 15;
        return (1024 + int'(h[9:0])) >>> (10 - e);
    endfunction

    function automatic logic [15:0] intToFp16(input int v);
        int msb;
        logic [15:0] r;
        if (v <= 0) return 16'h0000;
        msb = 0;
        for (int i = 0; i < 16; i++) if (v[i]) msb = i;
        r[15]    = 1'b0;
        r[14:10] = 5'(msb + 15);
        r[9:0]   = 10'((v << (10 - msb)) & 1023);
        return r;
    endfunction

    // Adder model: results and add_ready appear WC-1 edges after the start pulse;
    // in hold mode add_ready never drops and stale lanes carry junk until then.
    int  model_dly;
    logic model_pend;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            add_ready  <= 1'b0;
            model_pend <= 1'b0;
            model_dly  <= 0;
            for (int i = 0; i < NU; i++) add_out[i] <= 16'h0000;
        end else if (add_start) begin
            model_pend <= 1'b1;
            model_dly  <= WC - 1;
            if (!hold_ready) add_ready <= 1'b0;
            else for (int i = 0; i < NU; i++) add_out[i] <= 16'hBAD0;
        end else if (model_pend) begin
            if (model_dly <= 1) begin
                model_pend <= 1'b0;
                add_ready  <= 1'b1;
                for (int i = 0; i < NU; i++)
                    add_out[i] <= add_active_units[i] ?
                        intToFp16(fp16ToInt(add_x[i]) + fp16ToInt(add_bias[i])) : 16'hDEAD;
            end else begin
                model_dly <= model_dly - 1;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_ready ? ~out_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks masks,
    // start pulse width, capture latency, stall stability and busy release.
    logic          stalled = 1'b0, tile_first = 1'b0, busy_chk = 1'b0, prev_start = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;
    always @(negedge clk) begin
        logic [16:0]   e;
        logic [NU-1:0] m;
        cyc++;
        if (reset) begin
            stalled    = 1'b0;
            tile_first = 1'b0;
            busy_chk   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (busy_chk) begin
                checkOutput("busy_after_last", busy, 0);
                busy_chk = 1'b0;
            end
            if (in_ready)  in_ready_cycles++;
            if (out_valid) out_valid_cycles++;
            if (add_start) begin
                start_count++;
                last_start_cyc = cyc;
                tile_first     = 1'b1;
                checkOutput("add_start_width", prev_start, 0);
                if (exp_mask_q.size() == 0) begin
                    checkTrue("unexpected_add_start", 1'b0, start_count, 0);
                end else begin
                    m = exp_mask_q.pop_front();
                    checkOutput("add_active_units", add_active_units, m);
                end
            end
            prev_start = add_start;
            if (out_valid) begin
                if (tile_first) begin
                    checkTrue("capture_latency", (cyc - last_start_cyc) >= WC + 1,
                              cyc - last_start_cyc, WC + 1);
                    tile_first = 1'b0;
                end
                if (stalled) begin
                    checkOutput("stall_data_hold", out_data, held_data);
                    checkOutput("stall_last_hold", out_last, held_last);
                end
                if (out_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        checkTrue("unexpected_output", 1'b0, int'(out_data), 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", out_data, e[15:0]);
                        checkOutput("out_last", out_last, e[16]);
                        if (e[16]) busy_chk = 1'b1;
                    end
                end else begin
                    stalled   = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end
        end
    end

    task automatic sendCmd(input int len);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) checkTrue("cmd_timeout", 1'b0, t, 2000);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int gap_mod);
        int t;
        int lanes;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), stim_exp[i]});
        for (int k = 0; k * NU < n; k++) begin
            lanes = n - k * NU;
            exp_mask_q.push_back((lanes >= NU) ? {NU{1'b1}} : ((64'd1 << lanes) - 64'd1));
        end
        sendCmd(n);
        for (int i = 0; i < n; i++) begin
            if (gap_mod > 0) begin
                repeat (i % gap_mod) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = stim_x[i];
            in_bias  = stim_b[i];
            t = 0;
            while (!in_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                checkTrue("in_ready_timeout", 1'b0, t, 2000);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fillUniform(input int n, input logic [15:0] x, input logic [15:0] b, input logic [15:0] s);
        stim_x.delete();
        stim_b.delete();
        stim_exp.delete();
        for (int i = 0; i < n; i++) begin
            stim_x.push_back(x);
            stim_b.push_back(b);
            stim_exp.push_back(s);
        end
    endtask

    task automatic waitDrain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) checkTrue("drain_timeout", 1'b0, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_add_start"}, add_start, 0);
        checkOutput({tag, "_mask"}, add_active_units, 0);
        checkOutput({tag, "_add_x0"}, add_x[0], 0);
    endtask

    initial begin
        int s0, r0, o0, t;
        logic [15:0] ints [11];
        ints = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
                 16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980};
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0;
        in_valid = 1'b0; in_x = '0; in_bias = '0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        #2 reset = 1'b0;

        $display("[TB] N=64 single full tile");
        s0 = start_count;
        fillUniform(64, 16'h3C00, 16'h4000, 16'h4200);
        applyStimulus(64, 0);
        waitDrain();
        checkOutput("n64_starts", start_count - s0, 1);

        $display("[TB] N=70 two tiles");
        s0 = start_count;
        fillUniform(70, 16'h3C00, 16'h3C00, 16'h4000);
        applyStimulus(70, 0);
        waitDrain();
        checkOutput("n70_starts", start_count - s0, 2);

        $display("[TB] N=70 with add_ready held high");
        hold_ready = 1'b1;
        fillUniform(70, 16'h3C00, 16'h3C00, 16'h4000);
        applyStimulus(70, 0);
        waitDrain();
        hold_ready = 1'b0;

        $display("[TB] N=10 with stalls and input gaps");
        stim_x.delete(); stim_b.delete(); stim_exp.delete();
        for (int i = 0; i < 10; i++) begin
            stim_x.push_back(ints[i]);
            stim_b.push_back(16'h3C00);
            stim_exp.push_back(ints[i + 1]);
        end
        toggle_ready = 1'b1;
        applyStimulus(10, 3);
        waitDrain();
        toggle_ready = 1'b0;

        $display("[TB] zero-length command then N=1");
        s0 = start_count; r0 = in_ready_cycles; o0 = out_valid_cycles;
        sendCmd(0);
        repeat (6) @(negedge clk);
        checkOutput("zero_len_starts", start_count - s0, 0);
        checkOutput("zero_len_in_ready", in_ready_cycles - r0, 0);
        checkOutput("zero_len_out_valid", out_valid_cycles - o0, 0);
        checkOutput("zero_len_busy", busy, 0);
        fillUniform(1, 16'h4000, 16'h3C00, 16'h4200);
        applyStimulus(1, 0);
        waitDrain();

        $display("[TB] reset during WAIT then N=3");
        s0 = start_count;
        fillUniform(64, 16'h3C00, 16'h4000, 16'h4200);
        applyStimulus(64, 0);
        t = 0;
        while (start_count == s0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkTrue("abort_start_seen", start_count != s0, start_count - s0, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 checkResetState("midreset");
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        s0 = start_count; o0 = out_valid_cycles;
        repeat (12) @(negedge clk);
        checkOutput("post_reset_starts", start_count - s0, 0);
        checkOutput("post_reset_out_valid", out_valid_cycles - o0, 0);
        stim_x.delete(); stim_b.delete(); stim_exp.delete();
        for (int i = 0; i < 3; i++) begin
            stim_x.push_back(ints[i]);
            stim_b.push_back(16'h4000);
            stim_exp.push_back(ints[i + 2]);
        end
        applyStimulus(3, 0);
        waitDrain();

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        checkOutput("mask_queue_empty", exp_mask_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
